// File: rtl/rotation_ctrl.sv
// Piece-orientation controller: turns CW/CCW rotate keys into committed
// orientation changes with hold auto-repeat, collision veto and spawn lockout.
module rotation_ctrl #(
  parameter int          N_ORIENT      = 4,
  parameter int          ROT_W         = 2,
  parameter logic [7:0]  KEY_CW        = 8'h1A,
  parameter logic [7:0]  KEY_CCW       = 8'h14,
  parameter int          REPEAT_DELAY  = 24,
  parameter int          REPEAT_PERIOD = 6,
  parameter int          CNT_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       keycode,
  input  logic             blocked,
  input  logic             piece_load,
  output logic [ROT_W-1:0] rot_next,
  output logic [ROT_W-1:0] rotation,
  output logic             rot_event,
  output logic             rot_rejected
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} state_t;

  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(N_ORIENT - 1);
  // Terminal counts; the delay one is unused when auto-repeat is disabled.
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               AUTO_REP = (REPEAT_DELAY != 0);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [7:0]       held_key;
  logic             is_cw, is_ccw, is_rot, key_same, attempt;

  assign is_cw    = (keycode == KEY_CW);
  assign is_ccw   = (keycode == KEY_CCW);
  assign is_rot   = is_cw | is_ccw;
  assign key_same = (keycode == held_key);

  always_comb begin
    rot_next = rotation;
    if (is_cw)
      rot_next = (rotation == ROT_LAST) ? '0 : rotation + 1'b1;
    else if (is_ccw)
      rot_next = (rotation == '0) ? ROT_LAST : rotation - 1'b1;
  end

  // An attempt is taken on a fresh press, at the end of the initial hold
  // delay, and at each repeat period while the same key stays down.
  always_comb begin
    attempt = 1'b0;
    case (state)
      IDLE:    attempt = is_rot;
      HOLD:    attempt = AUTO_REP && key_same && (count == DLY_LAST);
      REPEAT:  attempt = key_same && (count == PER_LAST);
      default: attempt = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      count        <= '0;
      held_key     <= '0;
      rotation     <= '0;
      rot_event    <= 1'b0;
      rot_rejected <= 1'b0;
    end else if (piece_load) begin
      state        <= LOCKOUT;
      count        <= '0;
      rotation     <= '0;
      rot_event    <= 1'b0;
      rot_rejected <= 1'b0;
    end else begin
      rot_event    <= attempt & ~blocked;
      rot_rejected <= attempt & blocked;
      if (attempt && !blocked)
        rotation <= rot_next;

      case (state)
        IDLE: begin
          if (is_rot) begin
            held_key <= keycode;
            count    <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!key_same) begin
            count <= '0;
            state <= IDLE;
          end else if (AUTO_REP) begin
            if (count == DLY_LAST) begin
              count <= '0;
              state <= REPEAT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!key_same) begin
            count <= '0;
            state <= IDLE;
          end else if (count == PER_LAST) begin
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        LOCKOUT: begin
          // Wait for rotate keys to be released so a held key cannot
          // immediately spin the freshly spawned piece.
          if (!is_rot)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
